corefifo_ext_mem_ctrl: RTL and testbench

Single-clock FIFO controller that drives an external dual-port RAM of equal read/write width. It owns the write/read pointers and occupancy, and issues the address and enable strobes. It aligns the RAM's registered read data (1 or 2 cycles latency) with a valid strobe for the consumer. It sits between user logic and the external memory model/macro in the COREFIFO external-memory configuration.

---
 rtl/corefifo_ext_pkg.sv | 33 +++
 rtl/corefifo_ext_rvld_pipe.sv | 34 +++
 rtl/corefifo_ext_mem_ctrl.sv | 151 +++++++++++++++
 tb/tb_corefifo_ext_mem_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/corefifo_ext_pkg.sv
// corefifo_ext_pkg: shared constants and helpers for the COREFIFO
// external-memory controller (legal read-latency range, reset values,
// occupancy update rule).
package corefifo_ext_pkg;

  // Legal external RAM read latency, in cycles
  localparam int PIPE_MIN = 1;
  localparam int PIPE_MAX = 2;

  // Flag values held while reset is asserted
  localparam logic RST_EMPTY  = 1'b1;
  localparam logic RST_FULL   = 1'b0;
  localparam logic RST_AEMPTY = 1'b1;
  localparam logic RST_AFULL  = 1'b0;
  localparam logic RST_OVF    = 1'b0;
  localparam logic RST_UNF    = 1'b0;

  // Occupancy after one edge: +1 on write-only, -1 on read-only,
  // unchanged when both or neither are accepted
  function automatic logic [31:0] next_count(input logic [31:0] cur,
                                             input logic        wr_acc,
                                             input logic        rd_acc);
    logic [31:0] nxt;
    nxt = cur;
    if (wr_acc && !rd_acc) begin
      nxt = cur + 32'd1;
    end else if (rd_acc && !wr_acc) begin
      nxt = cur - 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/corefifo_ext_rvld_pipe.sv
// corefifo_ext_rvld_pipe: PIPE-deep shift register that delays the
// accepted-read strobe to line up with the RAM's registered output.
// The asynchronous clear drops any reads still in flight.
module corefifo_ext_rvld_pipe
  import corefifo_ext_pkg::*;
#(
  parameter int PIPE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_vld,
  output logic out_vld
);

  logic [PIPE-1:0] sr_q;
  logic [PIPE-1:0] sr_d;

  // Shift the new strobe in at bit 0; the oldest one leaves at the top
  always_comb begin
    sr_d = (sr_q << 1) | PIPE'(in_vld);
  end

  // Valid pipeline register, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign out_vld = sr_q[PIPE-1];

endmodule

// File: rtl/corefifo_ext_mem_ctrl.sv
// corefifo_ext_mem_ctrl: single-clock FIFO controller for an external
// dual-port RAM. Owns pointers and occupancy, drives the RAM strobes and
// aligns registered read data with rd_valid.
// Optional feature: define COREFIFO_EXT_CTRL_THRESH_EN to add the
// registered afull/aempty outputs.
module corefifo_ext_mem_ctrl
  import corefifo_ext_pkg::*;
#(
  parameter int WIDTH     = 18,
  parameter int AW        = 10,
  parameter int PIPE      = 1,
  parameter int AFULL_TH  = 1020,
  parameter int AEMPTY_TH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow,
  output logic             mem_we,
  output logic [AW-1:0]    mem_waddr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_re,
  output logic [AW-1:0]    mem_raddr,
  input  logic [WIDTH-1:0] mem_q
`ifdef COREFIFO_EXT_CTRL_THRESH_EN
  ,
  output logic             afull,
  output logic             aempty
`endif
);

  localparam int CW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  // Reject unsupported configurations at elaboration time
  if (PIPE < PIPE_MIN || PIPE > PIPE_MAX || AFULL_TH > DEPTH || AEMPTY_TH < 0) begin : g_cfg_err
    $error("corefifo_ext_mem_ctrl: illegal PIPE or threshold parameter");
  end

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wr_acc;
  logic          rd_acc;

  // Accept decisions come from the registered flags, so a full FIFO still
  // serves a read and an empty FIFO still takes a write in the same cycle
  always_comb begin
    wr_acc = wr_en && !full_q;
    rd_acc = rd_en && !empty_q;
  end

  // Pointer, occupancy and flag next-state; pointers wrap naturally
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (wr_acc) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (rd_acc) begin
      rptr_d = rptr_q + AW'(1);
    end
    count_d = CW'(next_count(32'(count_q), wr_acc, rd_acc));
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
    ovf_d   = wr_en && !wr_acc;
    unf_d   = rd_en && !rd_acc;
  end

  // Controller state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= RST_FULL;
      empty_q <= RST_EMPTY;
      ovf_q   <= RST_OVF;
      unf_q   <= RST_UNF;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

`ifdef COREFIFO_EXT_CTRL_THRESH_EN
  logic afull_q, afull_d;
  logic aempty_q, aempty_d;

  // Thresholds evaluated on the next-state count so they move with count
  always_comb begin
    afull_d  = (count_d >= CW'(AFULL_TH));
    aempty_d = (count_d <= CW'(AEMPTY_TH));
  end

  // Threshold flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      afull_q  <= RST_AFULL;
      aempty_q <= RST_AEMPTY;
    end else begin
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  assign afull  = afull_q;
  assign aempty = aempty_q;
`endif

  // Delay the accepted read by the RAM latency to flag rd_data
  corefifo_ext_rvld_pipe #(
    .PIPE (PIPE)
  ) u_rvld_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (rd_acc),
    .out_vld (rd_valid)
  );

  assign mem_we    = wr_acc && !rst;
  assign mem_waddr = wptr_q;
  assign mem_wdata = wr_data;
  assign mem_re    = rd_acc && !rst;
  assign mem_raddr = rptr_q;
  assign rd_data   = mem_q;

  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_corefifo_ext_mem_ctrl.sv
// tb_corefifo_ext_mem_ctrl: scoreboard bench for corefifo_ext_mem_ctrl with
// a behavioural dual-port RAM of PIPE-cycle read latency.
// Define COREFIFO_EXT_CTRL_THRESH_EN to also check afull/aempty.
module tb_corefifo_ext_mem_ctrl;

  localparam int WIDTH  = 18;
  localparam int AW     = 10;
  localparam int PIPE   = 2;
  localparam int DEPTH  = 1 << AW;
  localparam int PERIOD = 10;

  logic             clk;
  logic             rst;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_re;
  logic [AW-1:0]    mem_raddr;
  logic [WIDTH-1:0] mem_q;
`ifdef COREFIFO_EXT_CTRL_THRESH_EN
  logic             afull;
  logic             aempty;
`endif

  corefifo_ext_mem_ctrl #(
    .WIDTH     (WIDTH),
    .AW        (AW),
    .PIPE      (PIPE),
    .AFULL_TH  (1020),
    .AEMPTY_TH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_raddr (mem_raddr),
    .mem_q     (mem_q)
`ifdef COREFIFO_EXT_CTRL_THRESH_EN
    ,
    .afull     (afull),
    .aempty    (aempty)
`endif
  );

  initial clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  // Behavioural external RAM: registered read, optional second output stage
  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [WIDTH-1:0] q1, q2;
  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (mem_re) q1 <= mem[mem_raddr];
    q2 <= q1;
  end
  assign mem_q = (PIPE == 1) ? q1 : q2;

  typedef struct {
    logic [WIDTH-1:0] data;
    time              due;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] model_q[$];
  int               mdl_count;
  logic [AW-1:0]    mdl_wptr;
  logic [AW-1:0]    mdl_rptr;
  int               vec_count;
  int               miss_count;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // One cycle of stimulus: drive on negedge, update the model on the edge,
  // then check the registered outputs just after it
  task automatic applyStimulus(input logic we, input logic [WIDTH-1:0] wd, input logic re);
    logic wacc, racc;
    time  t_edge;
    @(negedge clk);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    wacc = we && (mdl_count < DEPTH);
    racc = re && (mdl_count > 0);
    #1;
    checkOutput("mem_we", 32'(mem_we), 32'(wacc));
    checkOutput("mem_re", 32'(mem_re), 32'(racc));
    if (wacc) begin
      checkOutput("mem_waddr", 32'(mem_waddr), 32'(mdl_wptr));
      checkOutput("mem_wdata", 32'(mem_wdata), 32'(wd));
    end
    if (racc) checkOutput("mem_raddr", 32'(mem_raddr), 32'(mdl_rptr));
    @(posedge clk);
    t_edge = $time;
    if (racc) begin
      exp_q.push_back('{model_q.pop_front(), t_edge + (PIPE-1)*PERIOD + PERIOD/2});
      mdl_rptr++;
    end
    if (wacc) begin
      model_q.push_back(wd);
      mdl_wptr++;
    end
    if (wacc && !racc) mdl_count++;
    if (racc && !wacc) mdl_count--;
    #1;
    checkOutput("count", 32'(count), 32'(mdl_count));
    checkOutput("full", 32'(full), 32'(mdl_count == DEPTH));
    checkOutput("empty", 32'(empty), 32'(mdl_count == 0));
    checkOutput("overflow", 32'(overflow), 32'(we && !wacc));
    checkOutput("underflow", 32'(underflow), 32'(re && !racc));
`ifdef COREFIFO_EXT_CTRL_THRESH_EN
    checkOutput("afull", 32'(afull), 32'(mdl_count >= 1020));
    checkOutput("aempty", 32'(aempty), 32'(mdl_count <= 4));
`endif
  endtask

  // Monitor: every rd_valid must match the oldest expected read in data
  // and arrival time; an overdue expected read is also reported
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("rd_valid_unexpected", 32'(rd_valid), 32'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("rd_data", 32'(rd_data), 32'(e.data));
          checkOutput("rd_latency", 32'($time), 32'(e.due));
        end
      end else if (exp_q.size() > 0 && $time >= exp_q[0].due) begin
        checkOutput("rd_valid_missing", 32'(rd_valid), 32'(1));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic resetModel();
    exp_q.delete();
    model_q.delete();
    mdl_count = 0;
    mdl_wptr  = '0;
    mdl_rptr  = '0;
  endtask

  initial begin
    vec_count  = 0;
    miss_count = 0;
    resetModel();
    rst     = 1'b1;
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = '0;
    #2;
    checkOutput("rst_count", 32'(count), 32'(0));
    checkOutput("rst_empty", 32'(empty), 32'(1));
    checkOutput("rst_full", 32'(full), 32'(0));
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'(0));
    checkOutput("rst_overflow", 32'(overflow), 32'(0));
    checkOutput("rst_underflow", 32'(underflow), 32'(0));
    checkOutput("rst_mem_we", 32'(mem_we), 32'(0));
    checkOutput("rst_mem_re", 32'(mem_re), 32'(0));
`ifdef COREFIFO_EXT_CTRL_THRESH_EN
    checkOutput("rst_afull", 32'(afull), 32'(0));
    checkOutput("rst_aempty", 32'(aempty), 32'(1));
`endif
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst   = 1'b0;

    // Three words in, three back-to-back reads out
    applyStimulus(1'b1, 18'h00001, 1'b0);
    applyStimulus(1'b1, 18'h00002, 1'b0);
    applyStimulus(1'b1, 18'h00003, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0);

    // Fill to full, then overflow and full with simultaneous read/write
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, WIDTH'(i * 7 + 5), 1'b0);
    applyStimulus(1'b1, 18'h3ffff, 1'b0);
    applyStimulus(1'b1, 18'h2aaaa, 1'b1);
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b0, '0, 1'b1);

    // Empty: underflow, then simultaneous read/write keeps one word
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, 18'h15555, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0);

    // Random traffic across pointer wrap
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), WIDTH'($urandom_range(0, (1 << WIDTH) - 1)),
                    1'($urandom_range(0, 1)));
    end
    while (mdl_count > 0) applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("pending_reads", 32'(exp_q.size()), 32'(0));

    // Reset with two reads in flight
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, WIDTH'(i + 100), 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    wr_en = 1'b1;
    rd_en = 1'b1;
    rst   = 1'b1;
    resetModel();
    #1;
    checkOutput("mid_rst_rd_valid", 32'(rd_valid), 32'(0));
    checkOutput("mid_rst_count", 32'(count), 32'(0));
    checkOutput("mid_rst_empty", 32'(empty), 32'(1));
    checkOutput("mid_rst_mem_we", 32'(mem_we), 32'(0));
    checkOutput("mid_rst_mem_re", 32'(mem_re), 32'(0));
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst   = 1'b0;

    // Normal operation resumes after reset
    applyStimulus(1'b1, 18'h0abcd, 1'b0);
    applyStimulus(1'b1, 18'h01234, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("final_pending_reads", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
